// File: rtl/st_pkt_decoder.sv
// ---------------------------------------------------------------------------
// st_pkt_decoder
//   Receive-side packet decoder. Parses a one-beat header (type, declared
//   payload length), collects payload bytes into a flat buffer and presents
//   the decoded message on a registered valid/ready output.
//
//   Optional feature macro: ST_PKT_DECODER_STATS_EN
//     When defined, adds saturating 16-bit message/error counters.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   i_pkt_valid/ready : input beat handshake (ready depends on state/rst only)
//   i_pkt_sop/eop     : packet delimiters (sop beat is the header)
//   i_pkt_data        : beat data, byte k at [8k+7:8k]
//   i_pkt_len         : valid bytes on an eop payload beat, 0 = full beat
//   o_msg_valid/ready : output message handshake
//   o_msg_type        : header byte 0
//   o_msg_payload     : payload byte n at [8n+7:8n], unused bytes zero
//   o_msg_bytes       : stored payload byte count (saturates at MAX_BYTES)
//   o_msg_err         : overflow or received-length != declared-length
//   o_stat_msgs/errs  : (STATS_EN only) handshake / error counters
// ---------------------------------------------------------------------------
module st_pkt_decoder #(
    parameter int WIDTH     = 32,
    parameter int MAX_BYTES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_pkt_valid,
    output logic                             i_pkt_ready,
    input  logic                             i_pkt_sop,
    input  logic                             i_pkt_eop,
    input  logic [WIDTH-1:0]                 i_pkt_data,
    input  logic [$clog2(WIDTH/8)-1:0]       i_pkt_len,
    output logic                             o_msg_valid,
    input  logic                             o_msg_ready,
    output logic [7:0]                       o_msg_type,
    output logic [MAX_BYTES*8-1:0]           o_msg_payload,
    output logic [$clog2(MAX_BYTES+1)-1:0]   o_msg_bytes,
`ifdef ST_PKT_DECODER_STATS_EN
    output logic [15:0]                      o_stat_msgs,
    output logic [15:0]                      o_stat_errs,
`endif
    output logic                             o_msg_err
);

    localparam int BPB   = WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_type;
    logic [7:0]             r_decl_len;
    logic [MAX_BYTES*8-1:0] r_payload;
    logic [CNT_W-1:0]       r_count;
    logic [7:0]             r_total;
    logic                   r_ovf;
    logic                   r_msg_valid;
    logic                   r_msg_err;

    logic [15:0]            w_nb;
    logic [15:0]            w_sum;
    logic [15:0]            w_tsum;
    logic [MAX_BYTES*8-1:0] w_payload;
    logic [CNT_W-1:0]       w_count;
    logic [7:0]             w_total;
    logic                   w_ovf;
    logic                   w_handshake;

    // Ready is a pure function of state and reset so it can never form a
    // combinational loop with an upstream valid.
    assign i_pkt_ready = !rst && (r_state != S_EMIT);
    assign w_handshake = (r_state == S_EMIT) && o_msg_ready;

    // Next buffer contents if the current beat is a payload beat.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_nb = 16'(BPB);
        if (i_pkt_eop && (i_pkt_len != '0))
            w_nb = 16'(i_pkt_len);

        w_sum  = 16'(r_count) + w_nb;
        w_tsum = 16'(r_total) + w_nb;

        // Byte k of the beat lands at index r_count + k; indices past the
        // buffer simply never match and are dropped.
        w_payload = r_payload;
        for (int n = 0; n < MAX_BYTES; n++) begin
            for (int k = 0; k < BPB; k++) begin
                if ((16'(k) < w_nb) && (int'(r_count) + k == n))
                    w_payload[n*8 +: 8] = i_pkt_data[k*8 +: 8];
            end
        end

        w_ovf   = r_ovf || (w_sum > 16'(MAX_BYTES));
        w_count = (w_sum > 16'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : CNT_W'(w_sum);
        w_total = (w_tsum > 16'd255) ? 8'hFF : w_tsum[7:0];
    end

`ifdef ST_PKT_DECODER_STATS_EN
    logic [15:0] r_stat_msgs;
    logic [15:0] r_stat_errs;
    assign o_stat_msgs = r_stat_msgs;
    assign o_stat_errs = r_stat_errs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_msgs <= '0;
            r_stat_errs <= '0;
        end else begin
            if (w_handshake && (r_stat_msgs != 16'hFFFF))
                r_stat_msgs <= r_stat_msgs + 16'd1;
            // A handshake (EMIT) and a discarded partial (COLLECT) are
            // mutually exclusive, so at most one increment per cycle.
            if (((w_handshake && r_msg_err) ||
                 ((r_state == S_COLLECT) && i_pkt_valid && i_pkt_sop)) &&
                (r_stat_errs != 16'hFFFF))
                r_stat_errs <= r_stat_errs + 16'd1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload buffer is reset too: it drives an output whose reset value is zero.
            r_state     <= S_IDLE;
            r_type      <= '0;
            r_decl_len  <= '0;
            r_payload   <= '0;
            r_count     <= '0;
            r_total     <= '0;
            r_ovf       <= 1'b0;
            r_msg_valid <= 1'b0;
            r_msg_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (i_pkt_valid) begin
                        if (i_pkt_sop) begin
                            // Header: also abandons any partial packet.
                            r_type     <= i_pkt_data[7:0];
                            r_decl_len <= i_pkt_data[15:8];
                            r_payload  <= '0;
                            r_count    <= '0;
                            r_total    <= '0;
                            r_ovf      <= 1'b0;
                            if (i_pkt_eop) begin
                                r_state     <= S_EMIT;
                                r_msg_valid <= 1'b1;
                                r_msg_err   <= (i_pkt_data[15:8] != 8'd0);
                            end else begin
                                r_state <= S_COLLECT;
                            end
                        end else if (r_state == S_COLLECT) begin
                            r_payload <= w_payload;
                            r_count   <= w_count;
                            r_total   <= w_total;
                            r_ovf     <= w_ovf;
                            if (i_pkt_eop) begin
                                r_state     <= S_EMIT;
                                r_msg_valid <= 1'b1;
                                r_msg_err   <= w_ovf || (w_total != r_decl_len);
                            end
                        end
                        // sop=0 in IDLE: stray beat, accepted and dropped.
                    end
                end
                S_EMIT: begin
                    if (o_msg_ready) begin
                        r_state     <= S_IDLE;
                        r_msg_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_msg_valid   = r_msg_valid;
    assign o_msg_type    = r_type;
    assign o_msg_payload = r_payload;
    assign o_msg_bytes   = r_count;
    assign o_msg_err     = r_msg_err;

endmodule

// File: tb/tb_st_pkt_decoder.sv
// ---------------------------------------------------------------------------
// tb_st_pkt_decoder
//   Directed self-checking bench for st_pkt_decoder (WIDTH=32, MAX_BYTES=16).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_st_pkt_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pkt_valid;
    logic         i_pkt_ready;
    logic         i_pkt_sop;
    logic         i_pkt_eop;
    logic [31:0]  i_pkt_data;
    logic [1:0]   i_pkt_len;
    logic         o_msg_valid;
    logic         o_msg_ready;
    logic [7:0]   o_msg_type;
    logic [127:0] o_msg_payload;
    logic [4:0]   o_msg_bytes;
    logic         o_msg_err;
`ifdef ST_PKT_DECODER_STATS_EN
    logic [15:0]  o_stat_msgs;
    logic [15:0]  o_stat_errs;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    st_pkt_decoder #(.WIDTH(32), .MAX_BYTES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_pkt_valid   (i_pkt_valid),
        .i_pkt_ready   (i_pkt_ready),
        .i_pkt_sop     (i_pkt_sop),
        .i_pkt_eop     (i_pkt_eop),
        .i_pkt_data    (i_pkt_data),
        .i_pkt_len     (i_pkt_len),
        .o_msg_valid   (o_msg_valid),
        .o_msg_ready   (o_msg_ready),
        .o_msg_type    (o_msg_type),
        .o_msg_payload (o_msg_payload),
        .o_msg_bytes   (o_msg_bytes),
`ifdef ST_PKT_DECODER_STATS_EN
        .o_stat_msgs   (o_stat_msgs),
        .o_stat_errs   (o_stat_errs),
`endif
        .o_msg_err     (o_msg_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat, wait (bounded) for ready, let it transfer, and
    // return on the falling edge after the transfer edge.
    task automatic send_beat(input logic sop, input logic eop,
                             input logic [31:0] data, input logic [1:0] len);
        int n = 0;
        i_pkt_valid = 1'b1;
        i_pkt_sop   = sop;
        i_pkt_eop   = eop;
        i_pkt_data  = data;
        i_pkt_len   = len;
        while (!i_pkt_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept", {127'd0, i_pkt_ready}, 128'd1);
        @(negedge clk);
        i_pkt_valid = 1'b0;
        i_pkt_sop   = 1'b0;
        i_pkt_eop   = 1'b0;
    endtask

    // Complete the output handshake and check the bubble cycle.
    task automatic consume(input string tag);
        o_msg_ready = 1'b1;
        @(negedge clk);
        o_msg_ready = 1'b0;
        check({tag, "_post_valid"}, {127'd0, o_msg_valid}, 128'd0);
        check({tag, "_post_ready"}, {127'd0, i_pkt_ready}, 128'd1);
    endtask

    initial begin
        rst         = 1'b1;
        i_pkt_valid = 1'b0;
        i_pkt_sop   = 1'b0;
        i_pkt_eop   = 1'b0;
        i_pkt_data  = '0;
        i_pkt_len   = '0;
        o_msg_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready",   {127'd0, i_pkt_ready}, 128'd0);
        check("rst_valid",   {127'd0, o_msg_valid}, 128'd0);
        check("rst_type",    {120'd0, o_msg_type},  128'd0);
        check("rst_payload", o_msg_payload,         128'd0);
        check("rst_bytes",   {123'd0, o_msg_bytes}, 128'd0);
        check("rst_err",     {127'd0, o_msg_err},   128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready",  {127'd0, i_pkt_ready}, 128'd1);

        // 1: type 3, L=6, one full beat then 2-byte eop beat.
        send_beat(1'b1, 1'b0, 32'h0000_0603, 2'd0);
        send_beat(1'b0, 1'b0, 32'h4433_2211, 2'd0);
        check("t1_valid_pre", {127'd0, o_msg_valid}, 128'd0);
        send_beat(1'b0, 1'b1, 32'h0000_BBAA, 2'd2);
        check("t1_valid",   {127'd0, o_msg_valid}, 128'd1);
        check("t1_ready",   {127'd0, i_pkt_ready}, 128'd0);
        check("t1_type",    {120'd0, o_msg_type},  128'h03);
        check("t1_bytes",   {123'd0, o_msg_bytes}, 128'd6);
        check("t1_payload", o_msg_payload,         128'h0000_0000_0000_0000_0000_BBAA_4433_2211);
        check("t1_err",     {127'd0, o_msg_err},   128'd0);
        consume("t1");

        // 2: header-only, L=0 then L=5.
        send_beat(1'b1, 1'b1, 32'h0000_0004, 2'd0);
        check("t2a_type",    {120'd0, o_msg_type},  128'h04);
        check("t2a_bytes",   {123'd0, o_msg_bytes}, 128'd0);
        check("t2a_payload", o_msg_payload,         128'd0);
        check("t2a_err",     {127'd0, o_msg_err},   128'd0);
        consume("t2a");
        send_beat(1'b1, 1'b1, 32'h0000_0504, 2'd0);
        check("t2b_type",    {120'd0, o_msg_type},  128'h04);
        check("t2b_err",     {127'd0, o_msg_err},   128'd1);
        consume("t2b");

        // 3: overflow, L=20, five full beats (last eop with len=0 = 4 bytes).
        send_beat(1'b1, 1'b0, 32'h0000_1405, 2'd0);
        send_beat(1'b0, 1'b0, 32'h0302_0100, 2'd0);
        send_beat(1'b0, 1'b0, 32'h0706_0504, 2'd0);
        send_beat(1'b0, 1'b0, 32'h0B0A_0908, 2'd0);
        send_beat(1'b0, 1'b0, 32'h0F0E_0D0C, 2'd0);
        send_beat(1'b0, 1'b1, 32'h1312_1110, 2'd0);
        check("t3_bytes",   {123'd0, o_msg_bytes}, 128'd16);
        check("t3_payload", o_msg_payload,         128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
        check("t3_err",     {127'd0, o_msg_err},   128'd1);
        consume("t3");

        // 4: partial packet abandoned by a new header.
        send_beat(1'b1, 1'b0, 32'h0000_0801, 2'd0);
        send_beat(1'b0, 1'b0, 32'hDEAD_BEEF, 2'd0);
        send_beat(1'b1, 1'b1, 32'h0000_0007, 2'd0);
        check("t4_type",    {120'd0, o_msg_type},  128'h07);
        check("t4_bytes",   {123'd0, o_msg_bytes}, 128'd0);
        check("t4_payload", o_msg_payload,         128'd0);
        check("t4_err",     {127'd0, o_msg_err},   128'd0);
        consume("t4");
`ifdef ST_PKT_DECODER_STATS_EN
        check("t4_stat_msgs", {112'd0, o_stat_msgs}, 128'd5);
        check("t4_stat_errs", {112'd0, o_stat_errs}, 128'd3);
`endif

        // 5: back-pressure for 10 cycles with a packet waiting.
        send_beat(1'b1, 1'b1, 32'h0000_0009, 2'd0);
        i_pkt_valid = 1'b1;
        i_pkt_sop   = 1'b1;
        i_pkt_eop   = 1'b1;
        i_pkt_data  = 32'h0000_000A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_ready", {127'd0, i_pkt_ready}, 128'd0);
            check("t5_hold_valid", {127'd0, o_msg_valid}, 128'd1);
            check("t5_hold_type",  {120'd0, o_msg_type},  128'h09);
        end
        o_msg_ready = 1'b1;
        @(negedge clk);
        o_msg_ready = 1'b0;
        check("t5_bubble_valid", {127'd0, o_msg_valid}, 128'd0);
        check("t5_bubble_ready", {127'd0, i_pkt_ready}, 128'd1);
        @(negedge clk);
        i_pkt_valid = 1'b0;
        i_pkt_sop   = 1'b0;
        i_pkt_eop   = 1'b0;
        check("t5_next_valid", {127'd0, o_msg_valid}, 128'd1);
        check("t5_next_type",  {120'd0, o_msg_type},  128'h0A);
        consume("t5");

        // 6: reset mid-COLLECT, stray beat, then a clean packet.
        send_beat(1'b1, 1'b0, 32'h0000_0302, 2'd0);
        send_beat(1'b0, 1'b0, 32'h5566_7788, 2'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", {127'd0, i_pkt_ready}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t6_valid",   {127'd0, o_msg_valid}, 128'd0);
        check("t6_type",    {120'd0, o_msg_type},  128'd0);
        check("t6_payload", o_msg_payload,         128'd0);
        check("t6_bytes",   {123'd0, o_msg_bytes}, 128'd0);
        check("t6_err",     {127'd0, o_msg_err},   128'd0);
`ifdef ST_PKT_DECODER_STATS_EN
        check("t6_stat_msgs", {112'd0, o_stat_msgs}, 128'd0);
        check("t6_stat_errs", {112'd0, o_stat_errs}, 128'd0);
`endif
        send_beat(1'b0, 1'b1, 32'hFFFF_FFFF, 2'd0);
        check("t6_stray_valid", {127'd0, o_msg_valid}, 128'd0);
        check("t6_stray_bytes", {123'd0, o_msg_bytes}, 128'd0);
        check("t6_stray_ready", {127'd0, i_pkt_ready}, 128'd1);
        send_beat(1'b1, 1'b0, 32'h0000_0206, 2'd0);
        send_beat(1'b0, 1'b1, 32'h0000_CDAB, 2'd2);
        check("t6_clean_type",    {120'd0, o_msg_type},  128'h06);
        check("t6_clean_bytes",   {123'd0, o_msg_bytes}, 128'd2);
        check("t6_clean_payload", o_msg_payload,         128'h0000_CDAB);
        check("t6_clean_err",     {127'd0, o_msg_err},   128'd0);
        consume("t6");

        // 7: short packet, L=5 but only 3 bytes received.
        send_beat(1'b1, 1'b0, 32'h0000_0508, 2'd0);
        send_beat(1'b0, 1'b1, 32'h00CC_BBAA, 2'd3);
        check("t7_bytes",   {123'd0, o_msg_bytes}, 128'd3);
        check("t7_payload", o_msg_payload,         128'h00CC_BBAA);
        check("t7_err",     {127'd0, o_msg_err},   128'd1);
        consume("t7");
`ifdef ST_PKT_DECODER_STATS_EN
        check("t7_stat_msgs", {112'd0, o_stat_msgs}, 128'd2);
        check("t7_stat_errs", {112'd0, o_stat_errs}, 128'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/st_pkt_decoder.md
# st_pkt_decoder

Receive-side counterpart of the streaming message encoder. Consumes the packet stream (valid/ready, sop/eop, WIDTH-bit data, byte-count `len`), parses the one-beat header, and collects the payload bytes into a flat message buffer. Presents message type, payload and byte count on a single registered valid/ready output. Sits at the far end of the packet link in the loopback/checker path and in the receive datapath.

## Interface
- `WIDTH`, 32: packet data width in bits; multiple of 8, at least 16.
- `MAX_BYTES`, 16: payload buffer capacity in bytes.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_pkt_valid` in 1: input beat valid.
- `i_pkt_ready` out 1: decoder accepts the beat this cycle.
- `i_pkt_sop` in 1: first beat of packet (header).
- `i_pkt_eop` in 1: last beat of packet.
- `i_pkt_data` in WIDTH: beat data; byte k at bits [8k+7:8k].
- `i_pkt_len` in $clog2(WIDTH/8): valid bytes on an eop payload beat; 0 means all WIDTH/8 bytes.
- `o_msg_valid` out 1: decoded message available.
- `o_msg_ready` in 1: consumer accepts message.
- `o_msg_type` out 8: header byte 0.
- `o_msg_payload` out MAX_BYTES*8: payload byte n at bits [8n+7:8n]; bytes at index ≥ `o_msg_bytes` are zero.
- `o_msg_bytes` out $clog2(MAX_BYTES+1): stored payload byte count.
- `o_msg_err` out 1: length mismatch or overflow.

## Operation
- Header beat (`sop`=1): data[7:0] is the type; data[15:8] is the declared payload length L in bytes. Remaining bits are ignored. `i_pkt_len` is ignored on the header beat.
- States:
  - IDLE: ready=1. A beat with sop=1 loads the type and L, clears the buffer, count and overflow flag. With eop=1 it goes to EMIT, otherwise to COLLECT. A beat with sop=0 is accepted and dropped.
  - COLLECT: ready=1. Each payload beat appends its valid bytes at the running count: WIDTH/8 bytes on a non-eop beat, `len`-decoded bytes on an eop beat. eop=1 goes to EMIT.
  - EMIT: ready=0, `o_msg_valid`=1. Outputs are stable until `o_msg_ready`=1, then the block returns to IDLE.
- Overflow: bytes that would land at index ≥ MAX_BYTES are discarded, the stored count saturates at MAX_BYTES, and a sticky overflow flag is set.
- `o_msg_err` = overflow OR (total received payload bytes ≠ L). The total-received counter is 8 bits wide and saturates at 255.
- sop=1 while in COLLECT: the partial message is silently discarded and the beat is processed as a new header.
- Header-only packet (sop=eop=1): `o_msg_bytes`=0, and `o_msg_err` = (L≠0).
- Reset:
  - State returns to IDLE.
  - `o_msg_valid`=0, `o_msg_type`=0, `o_msg_payload`=0, `o_msg_bytes`=0, `o_msg_err`=0.
  - `i_pkt_ready`=0 while `rst` is high.
  - Reset mid-packet or mid-EMIT discards all held data.

## Timing
- A beat transfers when `i_pkt_valid` & `i_pkt_ready` are both high on a rising edge.
- If eop is accepted at edge N, `o_msg_valid`=1 from N+1.
- If the output handshake completes at edge M, `o_msg_valid`=0 and `i_pkt_ready`=1 from M+1. This gives one bubble cycle between messages.
- All outputs are registered except `i_pkt_ready`, which is a function of state and `rst` only and never depends on `i_pkt_valid`.
- Minimum period: a P-beat packet occupies P input cycles plus at least 1 EMIT cycle.

## Configuration
- `ST_PKT_DECODER_STATS_EN` defined: adds two outputs, `o_stat_msgs` (16 bits) and `o_stat_errs` (16 bits).
  - Both reset to 0 and saturate at 0xFFFF.
  - `o_stat_msgs` increments on each output handshake.
  - `o_stat_errs` increments on each output handshake with `o_msg_err`=1, and on each discarded partial packet (sop in COLLECT).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Header 0x03 with L=6, then one payload beat (4 bytes, eop=0), then 0x…BBAA with eop=1, len=2 → one message: type=3, bytes=6, payload bytes 4..5 = AA,BB, err=0, `o_msg_valid` one cycle after eop.
- Header-only beat data=0x0004 (type 4, L=0) with sop=eop=1 → type=4, bytes=0, payload=0, err=0. Repeat with data=0x0504 → err=1.
- MAX_BYTES=16, L=20, five full payload beats → bytes=16, first 16 bytes stored, err=1 (overflow).
- Header with L=8, one payload beat, then a new sop header (type 7, L=0, eop) → the first packet is discarded, only type=7 is emitted. With STATS_EN, `o_stat_errs`=1 and `o_stat_msgs`=1.
- Hold `o_msg_ready`=0 for 10 cycles while `i_pkt_valid`=1 → `i_pkt_ready`=0 throughout and outputs stay stable. On release: handshake, one bubble cycle, then the next packet is accepted.
- Assert `rst` for one cycle mid-COLLECT → no message is emitted, all outputs are 0, and the next clean packet decodes correctly. Stray beats with sop=0 in IDLE are dropped.
